// File: rtl/subcarrier_reorder_pkg.sv
// Shared OFDM constants: symbol size, bank address width, sample width and Q1.15 field positions.
// Used by the pilot inserter, this reorder buffer and the IFFT wrapper.
package subcarrier_reorder_pkg;

  localparam int OFDM_NFFT = 64;
  localparam int OFDM_AW   = 6;
  localparam int OFDM_DW   = 32;

  localparam int OFDM_RE_LSB = 0;
  localparam int OFDM_RE_MSB = 15;
  localparam int OFDM_IM_LSB = 16;
  localparam int OFDM_IM_MSB = 31;

endpackage

// File: rtl/subcarrier_reorder_ram.sv
// Two-bank sample store, 2*NFFT x DW: one write port, one registered read port (bank bit = address MSB).
// One cycle read latency; rdat holds while re is low.
module subcarrier_reorder_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [DW-1:0] wdat,
  input  logic          re,
  input  logic [AW:0]   raddr,
  output logic [DW-1:0] rdat
);

  logic [DW-1:0] mem [0:(1<<(AW+1))-1];

  always_ff @(posedge CLK_I) begin
    if (we) mem[waddr] <= wdat;
  end

  // Only the output register is reset so the array still maps onto block RAM.
  always_ff @(posedge CLK_I) begin
    if (RST_I)   rdat <= '0;
    else if (re) rdat <= mem[raddr];
  end

endmodule

// File: rtl/subcarrier_reorder.sv
// Ping-pong buffer: natural-order subcarriers in, IFFT order out (half swap; SUBCARRIER_BITREV_EN adds bit reversal).
// First output two cycles after the last accept; ACK_O low while both banks full; DAT_O holds while ACK_I is low.
module subcarrier_reorder
  import subcarrier_reorder_pkg::*;
#(
  parameter int NFFT = OFDM_NFFT,
  parameter int AW   = OFDM_AW,
  parameter int DW   = OFDM_DW
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          CYC_I,
  input  logic          WE_I,
  input  logic          STB_I,
  output logic          ACK_O,
  output logic [AW-1:0] dataCount,
  output logic [DW-1:0] DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I
);

  localparam logic [AW-1:0] LAST = AW'(NFFT - 1);
  localparam logic [AW-1:0] HALF = AW'(NFFT / 2);

  logic          cyc_d, cyc_rise, cyc_fall, ena;
  logic          issue, wr_last, rd_last;
  logic [1:0]    full;
  logic          wr_bank, rd_bank, stb_q, cyc_q;
  logic [AW-1:0] wr_cnt, wr_addr, rd_cnt, rd_ord, rd_addr;

  always_comb begin
    ena      = CYC_I & STB_I & WE_I;
    cyc_rise = CYC_I & ~cyc_d;
    cyc_fall = ~CYC_I & cyc_d;
    ACK_O    = ena & ~full[wr_bank];
    // A new burst always starts at subcarrier 0, even if it accepts on its first cycle.
    wr_addr  = cyc_rise ? '0 : wr_cnt;
    wr_last  = ACK_O & (wr_addr == LAST);
    issue    = full[rd_bank] & (~stb_q | ACK_I);
    rd_last  = issue & (rd_cnt == LAST);
  end

  always_comb begin
    rd_ord = rd_cnt;
`ifdef SUBCARRIER_BITREV_EN
    for (int i = 0; i < AW; i++) rd_ord[i] = rd_cnt[AW-1-i];
`endif
    rd_addr = rd_ord ^ HALF;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cyc_d   <= 1'b0;
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else begin
      cyc_d <= CYC_I;
      if (ACK_O)                  wr_cnt <= wr_addr + AW'(1);
      else if (cyc_rise | cyc_fall) wr_cnt <= '0;
      if (wr_last) wr_bank <= ~wr_bank;
    end
  end

  // Write and read never target the same bank, so both flag updates can land together.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      full <= 2'b00;
    end else begin
      if (wr_last) full[wr_bank] <= 1'b1;
      if (rd_last) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      if (issue)   rd_cnt  <= rd_cnt + AW'(1);
      if (rd_last) rd_bank <= ~rd_bank;
      if (issue)        stb_q <= 1'b1;
      else if (ACK_I)   stb_q <= 1'b0;
      if (issue && rd_cnt == '0)                      cyc_q <= 1'b1;
      else if (full == 2'b00 && !stb_q && !CYC_I)     cyc_q <= 1'b0;
    end
  end

  subcarrier_reorder_ram #(.AW(AW), .DW(DW)) u_ram (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .we    (ACK_O),
    .waddr ({wr_bank, wr_addr}),
    .wdat  (DAT_I),
    .re    (issue),
    .raddr ({rd_bank, rd_addr}),
    .rdat  (DAT_O)
  );

  assign STB_O     = stb_q;
  assign WE_O      = stb_q;
  assign CYC_O     = cyc_q;
  assign dataCount = wr_cnt;

endmodule

// File: tb/tb_subcarrier_reorder.sv
// Directed bench for subcarrier_reorder: reorder pattern, latency, back-pressure, bank-full stall, CYC_I drop, reset.
module tb_subcarrier_reorder;

  logic        clk;
  logic        RST_I, CYC_I, WE_I, STB_I, ACK_I;
  logic [31:0] DAT_I;
  logic        ACK_O, CYC_O, STB_O, WE_O;
  logic [5:0]  dataCount;
  logic [31:0] DAT_O;

  subcarrier_reorder dut (
    .CLK_I(clk), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .WE_I(WE_I), .STB_I(STB_I),
    .ACK_O(ACK_O), .dataCount(dataCount), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .WE_O(WE_O), .ACK_I(ACK_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc_cnt = 0;
  int n_acc = 0;
  int acc_before = 0;
  int we_bad = 0;
  logic [31:0] send_q[$];
  logic [31:0] out_q[$];
  logic cyc_drv = 1'b0, ack_drv = 1'b0, rst_drv = 1'b1;
  logic obs_ack, obs_stb, obs_cyc;
  logic [31:0] obs_dat;
  logic [5:0] obs_dc;

  // Output position k of a symbol carries stored subcarrier exp_idx(k).
  function automatic int exp_idx(input int k);
`ifdef SUBCARRIER_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if (k[b]) r = r | (1 << (5 - b));
    return r ^ 32;
`else
    return (k + 32) % 64;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc_cnt++;
    RST_I = rst_drv;
    CYC_I = cyc_drv;
    if (cyc_drv && send_q.size() > 0) begin
      STB_I = 1'b1; WE_I = 1'b1; DAT_I = send_q[0];
    end else begin
      STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0;
    end
    ACK_I = ack_drv;
    @(negedge clk);
    obs_ack = ACK_O; obs_stb = STB_O; obs_dat = DAT_O; obs_cyc = CYC_O; obs_dc = dataCount;
    acc_before = n_acc;
    if (WE_O !== STB_O) we_bad++;
    if (ACK_O === 1'b1) begin
      void'(send_q.pop_front());
      n_acc++;
    end
    if (STB_O === 1'b1 && ACK_I) out_q.push_back(DAT_O);
  endtask

  task automatic do_reset();
    rst_drv = 1'b1; cyc_drv = 1'b0; ack_drv = 1'b0;
    send_q.delete();
    step();
    step();
    rst_drv = 1'b0;
    out_q.delete();
    n_acc = 0;
  endtask

  task automatic push_symbol(input int base);
    for (int i = 0; i < 64; i++) send_q.push_back(32'(base + i));
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if (obs_stb !== 1'b0 || obs_cyc !== 1'b0) $display("FAIL reset_stb_cyc: STB_O=%b CYC_O=%b, expected 0 0", obs_stb, obs_cyc);
    else passed++;
    checks++;
    if (obs_dat !== 32'h0) $display("FAIL reset_dat: DAT_O=%h, expected 0", obs_dat);
    else passed++;
    checks++;
    if (obs_ack !== 1'b0 || obs_dc !== 6'd0) $display("FAIL reset_ack_count: ACK_O=%b dataCount=%0d, expected 0 0", obs_ack, obs_dc);
    else passed++;
  endtask

  task automatic test_single();
    int last_acc, first_stb, run, maxrun, dc5, bad, first_bad;
    logic cyc_at_first;
    last_acc = -1; first_stb = -1; run = 0; maxrun = 0; dc5 = -1; cyc_at_first = 1'b0;
    do_reset();
    push_symbol(0);
    cyc_drv = 1'b1; ack_drv = 1'b1;
    for (int i = 0; i < 300 && out_q.size() < 64; i++) begin
      step();
      if (send_q.size() == 0) cyc_drv = 1'b0;
      if (acc_before == 5 && dc5 < 0) dc5 = int'(obs_dc);
      if (obs_ack) last_acc = cyc_cnt;
      if (obs_stb && first_stb < 0) begin first_stb = cyc_cnt; cyc_at_first = obs_cyc; end
      run = obs_stb ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    checks++;
    if (dc5 !== 5) $display("FAIL datacount: dataCount=%0d after 5 accepts, expected 5", dc5);
    else passed++;
    checks++;
    if (first_stb - last_acc !== 2) $display("FAIL latency: first STB_O %0d cycles after last ACK_O, expected 2", first_stb - last_acc);
    else passed++;
    checks++;
    if (maxrun !== 64) $display("FAIL stb_run: %0d consecutive STB_O cycles, expected 64", maxrun);
    else passed++;
    checks++;
    if (cyc_at_first !== 1'b1) $display("FAIL cyc_o_set: CYC_O=%b with first STB_O, expected 1", cyc_at_first);
    else passed++;
    bad = 0; first_bad = 0;
    for (int k = 0; k < out_q.size(); k++)
      if (out_q[k] !== 32'(exp_idx(k))) begin if (bad == 0) first_bad = k; bad++; end
    checks++;
    if (out_q.size() != 64 || bad != 0)
      $display("FAIL single_order: %0d outputs, %0d wrong (first at %0d), expected 64 outputs 0 wrong", out_q.size(), bad, first_bad);
    else passed++;
    step(); step(); step();
    checks++;
    if (obs_cyc !== 1'b0) $display("FAIL cyc_o_clear: CYC_O=%b after drain with CYC_I low, expected 0", obs_cyc);
    else passed++;
  endtask

  task automatic test_addr_map();
    int e0, e1, e2;
`ifdef SUBCARRIER_BITREV_EN
    e0 = 32; e1 = 0; e2 = 48;
`else
    e0 = 32; e1 = 33; e2 = 34;
`endif
    checks++;
    if (out_q.size() < 3 || out_q[0] !== 32'(e0) || out_q[1] !== 32'(e1) || out_q[2] !== 32'(e2))
      $display("FAIL addr_map: first outputs %0d %0d %0d, expected %0d %0d %0d",
               out_q.size() > 0 ? out_q[0] : 0, out_q.size() > 1 ? out_q[1] : 0, out_q.size() > 2 ? out_q[2] : 0, e0, e1, e2);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int first_acc, last_acc, first_stb, last_stb, n_stb, bad;
    first_acc = -1; last_acc = -1; first_stb = -1; last_stb = -1; n_stb = 0;
    do_reset();
    for (int s = 0; s < 3; s++) push_symbol(s * 64);
    cyc_drv = 1'b1; ack_drv = 1'b1;
    for (int i = 0; i < 600 && out_q.size() < 192; i++) begin
      step();
      if (send_q.size() == 0) cyc_drv = 1'b0;
      if (obs_ack) begin if (first_acc < 0) first_acc = cyc_cnt; last_acc = cyc_cnt; end
      if (obs_stb) begin if (first_stb < 0) first_stb = cyc_cnt; last_stb = cyc_cnt; n_stb++; end
    end
    checks++;
    if (last_acc - first_acc !== 191) $display("FAIL b2b_ack: accept span %0d cycles, expected 191", last_acc - first_acc);
    else passed++;
    checks++;
    if (last_stb - first_stb !== 191 || n_stb !== 192) $display("FAIL b2b_gapfree: span %0d count %0d, expected 191 192", last_stb - first_stb, n_stb);
    else passed++;
    bad = 0;
    for (int k = 0; k < out_q.size(); k++)
      if (out_q[k] !== 32'((k / 64) * 64 + exp_idx(k % 64))) bad++;
    checks++;
    if (out_q.size() != 192 || bad != 0) $display("FAIL b2b_order: %0d outputs %0d wrong, expected 192 0", out_q.size(), bad);
    else passed++;
  endtask

  task automatic test_backpressure();
    int held, hold_ok, bad;
    held = 0; hold_ok = 0;
    do_reset();
    push_symbol(0);
    cyc_drv = 1'b1;
    for (int i = 0; i < 300 && out_q.size() < 64; i++) begin
      ack_drv = (out_q.size() == 10 && held < 5) ? 1'b0 : 1'b1;
      step();
      if (send_q.size() == 0) cyc_drv = 1'b0;
      if (!ack_drv) begin
        held++;
        if (obs_stb && obs_dat == 32'(exp_idx(10))) hold_ok++;
      end
    end
    checks++;
    if (hold_ok !== 5) $display("FAIL bp_hold: DAT_O held at %0d for %0d cycles, expected 5", exp_idx(10), hold_ok);
    else passed++;
    bad = 0;
    for (int k = 0; k < out_q.size(); k++) if (out_q[k] !== 32'(exp_idx(k))) bad++;
    checks++;
    if (out_q.size() != 64 || bad != 0) $display("FAIL bp_order: %0d outputs %0d wrong, expected 64 0", out_q.size(), bad);
    else passed++;
  endtask

  task automatic test_stall();
    int t0, resume, bad;
    resume = -1;
    do_reset();
    for (int s = 0; s < 3; s++) push_symbol(s * 64);
    cyc_drv = 1'b1; ack_drv = 1'b0;
    for (int i = 0; i < 200; i++) step();
    checks++;
    if (n_acc !== 128) $display("FAIL stall_accepts: %0d accepted with ACK_I low, expected 128", n_acc);
    else passed++;
    checks++;
    if (obs_stb !== 1'b1 || obs_dat !== 32'(exp_idx(0))) $display("FAIL stall_hold: STB_O=%b DAT_O=%0d, expected 1 %0d", obs_stb, obs_dat, exp_idx(0));
    else passed++;
    ack_drv = 1'b1;
    t0 = cyc_cnt + 1;
    for (int i = 0; i < 600 && out_q.size() < 192; i++) begin
      step();
      if (send_q.size() == 0) cyc_drv = 1'b0;
      if (obs_ack && resume < 0) resume = cyc_cnt;
    end
    checks++;
    if (resume - t0 !== 63) $display("FAIL stall_resume: ACK_O resumed %0d cycles after ACK_I, expected 63", resume - t0);
    else passed++;
    bad = 0;
    for (int k = 0; k < out_q.size(); k++)
      if (out_q[k] !== 32'((k / 64) * 64 + exp_idx(k % 64))) bad++;
    checks++;
    if (out_q.size() != 192 || bad != 0) $display("FAIL stall_order: %0d outputs %0d wrong, expected 192 0", out_q.size(), bad);
    else passed++;
  endtask

  task automatic test_cyc_drop();
    int any_stb, bad;
    any_stb = 0;
    do_reset();
    for (int i = 0; i < 20; i++) send_q.push_back(32'(1000 + i));
    cyc_drv = 1'b1; ack_drv = 1'b1;
    for (int i = 0; i < 50 && n_acc < 20; i++) step();
    cyc_drv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (obs_stb) any_stb++;
    end
    checks++;
    if (any_stb !== 0 || obs_dc !== 6'd0) $display("FAIL cyc_drop_idle: STB_O cycles %0d dataCount %0d, expected 0 0", any_stb, obs_dc);
    else passed++;
    push_symbol(0);
    cyc_drv = 1'b1;
    for (int i = 0; i < 300 && out_q.size() < 64; i++) begin
      step();
      if (send_q.size() == 0) cyc_drv = 1'b0;
    end
    bad = 0;
    for (int k = 0; k < out_q.size(); k++) if (out_q[k] !== 32'(exp_idx(k))) bad++;
    checks++;
    if (out_q.size() != 64 || bad != 0) $display("FAIL cyc_drop_order: %0d outputs %0d wrong, expected 64 0", out_q.size(), bad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int any_stb;
    any_stb = 0;
    out_q.delete();
    push_symbol(100);
    cyc_drv = 1'b1; ack_drv = 1'b1;
    for (int i = 0; i < 300 && out_q.size() < 5; i++) begin
      step();
      if (send_q.size() == 0) cyc_drv = 1'b0;
    end
    rst_drv = 1'b1; cyc_drv = 1'b0;
    send_q.delete();
    step();
    rst_drv = 1'b0;
    step();
    checks++;
    if (obs_stb !== 1'b0 || obs_cyc !== 1'b0 || obs_dat !== 32'h0 || obs_ack !== 1'b0 || obs_dc !== 6'd0)
      $display("FAIL reset_mid: STB_O=%b CYC_O=%b DAT_O=%h ACK_O=%b dataCount=%0d, expected all 0",
               obs_stb, obs_cyc, obs_dat, obs_ack, obs_dc);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_stb) any_stb++;
    end
    checks++;
    if (any_stb !== 0) $display("FAIL reset_discard: %0d STB_O cycles after reset, expected 0", any_stb);
    else passed++;
  endtask

  initial begin
    RST_I = 1'b1; CYC_I = 1'b0; WE_I = 1'b0; STB_I = 1'b0; ACK_I = 1'b0; DAT_I = '0;
    test_reset();
    test_single();
    test_addr_map();
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_cyc_drop();
    test_reset_mid();
    checks++;
    if (we_bad !== 0) $display("FAIL we_o: WE_O differed from STB_O in %0d cycles, expected 0", we_bad);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
